// File: rtl/dmg_bus_pkg.sv
// Shared bus definitions for the DMG memory responder.
// FSM state encoding plus fixed internal address map.
package dmg_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT,
        EXT,
        DONE,
        RELEASE
    } state_t;

    localparam logic [15:0] HRAM_BASE = 16'hFF80;
    localparam logic [15:0] IE_ADDR   = 16'hFFFF;
    localparam logic [7:0]  OPEN_BUS  = 8'hFF;

    function automatic logic in_hram(input logic [15:0] a);
        return (a >= HRAM_BASE) && (a != IE_ADDR);
    endfunction

endpackage

// File: rtl/hram_127x8.sv
// 127-byte high RAM: synchronous write, combinational read.
// Index 0x7F is not storage (it aliases IE in the address map).
module hram_127x8 (
    input  logic       CLK,
    input  logic       i_we,
    input  logic [6:0] i_waddr,
    input  logic [7:0] i_wdata,
    input  logic [6:0] i_raddr,
    output logic [7:0] o_rdata
);

    logic [7:0] r_mem [0:126];

    always_ff @(posedge CLK) begin
        if (i_we && (i_waddr != 7'h7F)) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = (i_raddr == 7'h7F) ? 8'hFF : r_mem[i_raddr];

endmodule

// File: rtl/mem_responder.sv
// Core-side memory responder: IE register, optional HRAM, external port.
// Define MEM_RESPONDER_HRAM_EN to serve FF80-FFFE from internal HRAM.
module mem_responder #(
    parameter int WAIT_CYCLES = 1,
    parameter int EXT_TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        SYNC_RES,
    input  logic [15:0] A,
    input  logic [7:0]  DOUT,
    input  logic        RD,
    input  logic        WR,
    output logic [7:0]  DIN,
    output logic        READY,
    output logic        TIMEOUT,
    output logic [15:0] EXT_A,
    output logic [7:0]  EXT_DO,
    input  logic [7:0]  EXT_DI,
    output logic        EXT_RD,
    output logic        EXT_WR,
    input  logic        EXT_ACK
);

    import dmg_bus_pkg::*;

    localparam logic [2:0] LP_WAIT    = 3'(WAIT_CYCLES);
    localparam logic [7:0] LP_TO_LAST = 8'(EXT_TIMEOUT - 1);
`ifdef MEM_RESPONDER_HRAM_EN
    localparam bit LP_HRAM = 1'b1;
`else
    localparam bit LP_HRAM = 1'b0;
`endif

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_addr;
    logic [7:0]  r_data;
    logic        r_wr;
    logic        r_int;
    logic        r_to;
    logic [7:0]  r_din;
    logic [7:0]  r_ie;
    logic [2:0]  r_wcnt;
    logic [7:0]  r_tcnt;

    logic        w_req;
    logic        w_is_int;
    logic [15:0] w_rd_addr;
    logic [7:0]  w_hram_rdata;
    logic [7:0]  w_int_rdata;
    logic        w_int_rd_done;
    logic        w_commit;

    assign w_req     = RD ^ WR;
    assign w_is_int  = (A == IE_ADDR) || (LP_HRAM && in_hram(A));
    // With zero wait states the read completes straight from IDLE,
    // before the address latch has been loaded.
    assign w_rd_addr = (r_state == IDLE) ? A : r_addr;
    assign w_int_rdata = (w_rd_addr == IE_ADDR) ? r_ie : w_hram_rdata;
    assign w_commit  = (r_state == DONE) && r_wr && r_int;

    assign w_int_rd_done = (w_next == DONE) &&
        (((r_state == IDLE) && RD) ||
         ((r_state == WAIT) && !r_wr));

`ifdef MEM_RESPONDER_HRAM_EN
    hram_127x8 u_hram (
        .CLK     (CLK),
        .i_we    (w_commit && (r_addr != IE_ADDR) && !SYNC_RES),
        .i_waddr (r_addr[6:0]),
        .i_wdata (r_data),
        .i_raddr (w_rd_addr[6:0]),
        .o_rdata (w_hram_rdata)
    );
`else
    assign w_hram_rdata = OPEN_BUS;
`endif

    always_ff @(posedge CLK) begin
        if (SYNC_RES) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (!w_is_int) begin
                        w_next = EXT;
                    end else if (LP_WAIT == 3'd0) begin
                        w_next = DONE;
                    end else begin
                        w_next = WAIT;
                    end
                end
            end
            WAIT:    if (r_wcnt <= 3'd1) w_next = DONE;
            EXT:     if (EXT_ACK || (r_tcnt == LP_TO_LAST)) w_next = DONE;
            DONE:    w_next = RELEASE;
            RELEASE: if (!RD && !WR) w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (SYNC_RES) begin
            r_addr <= '0;
            r_data <= '0;
            r_wr   <= 1'b0;
            r_int  <= 1'b0;
            r_to   <= 1'b0;
            r_din  <= OPEN_BUS;
            r_ie   <= '0;
            r_wcnt <= '0;
            r_tcnt <= '0;
        end else begin
            if ((r_state == IDLE) && w_req) begin
                r_addr <= A;
                r_data <= DOUT;
                r_wr   <= WR;
                r_int  <= w_is_int;
                r_to   <= 1'b0;
                r_wcnt <= LP_WAIT;
                r_tcnt <= '0;
            end
            if (r_state == WAIT) begin
                r_wcnt <= r_wcnt - 3'd1;
            end
            if (r_state == EXT) begin
                if (EXT_ACK) begin
                    if (!r_wr) r_din <= EXT_DI;
                end else if (r_tcnt == LP_TO_LAST) begin
                    r_to <= 1'b1;
                    if (!r_wr) r_din <= OPEN_BUS;
                end else begin
                    r_tcnt <= r_tcnt + 8'd1;
                end
            end
            if (w_int_rd_done) begin
                r_din <= w_int_rdata;
            end
            if (w_commit && (r_addr == IE_ADDR)) begin
                r_ie <= r_data;
            end
        end
    end

    assign READY   = (r_state == DONE);
    assign TIMEOUT = READY && r_to;
    assign EXT_RD  = (r_state == EXT) && !r_wr;
    assign EXT_WR  = (r_state == EXT) && r_wr;
    assign EXT_A   = r_addr;
    assign EXT_DO  = r_data;
    assign DIN     = r_din;

endmodule

// File: tb/tb_mem_responder.sv
// Self-checking bench for mem_responder (WAIT_CYCLES=1, EXT_TIMEOUT=4).
// Table of accesses with a completion scoreboard, plus corner sequences.
module tb_mem_responder;

    logic        CLK = 1'b0;
    logic        SYNC_RES = 1'b1;
    logic [15:0] A = '0;
    logic [7:0]  DOUT = '0;
    logic        RD = 1'b0;
    logic        WR = 1'b0;
    logic [7:0]  DIN;
    logic        READY;
    logic        TIMEOUT;
    logic [15:0] EXT_A;
    logic [7:0]  EXT_DO;
    logic [7:0]  EXT_DI = '0;
    logic        EXT_RD;
    logic        EXT_WR;
    logic        EXT_ACK = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        bit          rd;
        bit          wr;
        logic [15:0] addr;
        logic [7:0]  wdata;
        int          ack;
        logic [7:0]  di;
        bit          ext;
        int          lat;
        logic [7:0]  din;
        bit          to;
    } vec_t;

    typedef struct {
        int         lat;
        logic [7:0] din;
        bit         to;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[10];

    mem_responder #(
        .WAIT_CYCLES (1),
        .EXT_TIMEOUT (4)
    ) dut (
        .CLK      (CLK),
        .SYNC_RES (SYNC_RES),
        .A        (A),
        .DOUT     (DOUT),
        .RD       (RD),
        .WR       (WR),
        .DIN      (DIN),
        .READY    (READY),
        .TIMEOUT  (TIMEOUT),
        .EXT_A    (EXT_A),
        .EXT_DO   (EXT_DO),
        .EXT_DI   (EXT_DI),
        .EXT_RD   (EXT_RD),
        .EXT_WR   (EXT_WR),
        .EXT_ACK  (EXT_ACK)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit rd, bit wr, logic [15:0] addr,
                                logic [7:0] wdata, int ack, logic [7:0] di,
                                bit ext, int lat, logic [7:0] din, bit to);
        vec_t v;
        v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata;
        v.ack = ack; v.di = di; v.ext = ext; v.lat = lat;
        v.din = din; v.to = to;
        return v;
    endfunction

    task automatic run_access(input vec_t v);
        exp_t e;
        int   n;
        int   strb;
        bit   seen;
        e.lat = v.lat; e.din = v.din; e.to = v.to;
        @(negedge CLK);
        RD = v.rd; WR = v.wr; A = v.addr; DOUT = v.wdata;
        sb.push_back(e);
        seen = 0; strb = 0; n = 0;
        while (!seen && n < 12) begin
            @(negedge CLK);
            n++;
            if (n == 1) begin
                A = ~v.addr;
                DOUT = ~v.wdata;
            end
            EXT_ACK = 1'b0;
            if (EXT_RD || EXT_WR) begin
                strb++;
                if (strb == 1) begin
                    check("ext_a", EXT_A, v.addr);
                    check("ext_dir", {EXT_RD, EXT_WR}, {v.rd, v.wr});
                    if (v.wr) check("ext_do", EXT_DO, v.wdata);
                end
            end
            if (READY) begin
                seen = 1;
                e = sb.pop_front();
                check("latency", n, e.lat);
                check("din", DIN, e.din);
                check("timeout", TIMEOUT, e.to);
            end else if ((EXT_RD || EXT_WR) && n == v.ack) begin
                EXT_ACK = 1'b1;
                EXT_DI = v.di;
            end
        end
        if (!seen) begin
            check("ready_seen", 0, 1);
            void'(sb.pop_front());
        end
        check("strobe_cycles", strb, v.ext ? v.lat - 1 : 0);
        RD = 1'b0; WR = 1'b0; EXT_ACK = 1'b0;
        @(negedge CLK);
        check("ready_pulse", READY, 0);
        @(negedge CLK);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rdy;
        int strb;
        vecs[0] = mk(0, 1, 16'hFFFF, 8'h1F, 0, 8'h00, 0, 2, 8'hFF, 0);
        vecs[1] = mk(1, 0, 16'hFFFF, 8'h00, 0, 8'h00, 0, 2, 8'h1F, 0);
        vecs[2] = mk(1, 0, 16'h1234, 8'h00, 3, 8'hC3, 1, 4, 8'hC3, 0);
        vecs[3] = mk(1, 0, 16'h4000, 8'h00, 0, 8'h00, 1, 5, 8'hFF, 1);
        vecs[4] = mk(0, 1, 16'h8000, 8'h55, 1, 8'h00, 1, 2, 8'hFF, 0);
        vecs[5] = mk(1, 0, 16'h0001, 8'h00, 1, 8'h3C, 1, 2, 8'h3C, 0);
        vecs[6] = mk(0, 1, 16'h2000, 8'hAA, 0, 8'h00, 1, 5, 8'h3C, 1);
`ifdef MEM_RESPONDER_HRAM_EN
        vecs[7] = mk(0, 1, 16'hFF90, 8'h5A, 0, 8'h00, 0, 2, 8'h3C, 0);
        vecs[8] = mk(1, 0, 16'hFF90, 8'h00, 0, 8'h00, 0, 2, 8'h5A, 0);
`else
        vecs[7] = mk(1, 0, 16'hFF80, 8'h00, 2, 8'h77, 1, 3, 8'h77, 0);
        vecs[8] = mk(0, 1, 16'hFFFE, 8'h12, 1, 8'h00, 1, 2, 8'h77, 0);
`endif
        vecs[9] = mk(1, 0, 16'hFFFF, 8'h00, 0, 8'h00, 0, 2, 8'h1F, 0);

        repeat (3) @(negedge CLK);
        SYNC_RES = 1'b0;
        check("rst_ready", READY, 0);
        check("rst_timeout", TIMEOUT, 0);
        check("rst_strobes", {EXT_RD, EXT_WR}, 0);
        check("rst_ext_a", EXT_A, 0);
        check("rst_ext_do", EXT_DO, 0);
        check("rst_din", DIN, 8'hFF);

        for (int i = 0; i < 10; i++) begin
            run_access(vecs[i]);
        end

        // RD held across completion must be serviced once only
        @(negedge CLK);
        RD = 1'b1; A = 16'hFFFF;
        rdy = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge CLK);
            if (READY) rdy++;
        end
        RD = 1'b0;
        check("held_rd_ready_cnt", rdy, 1);
        check("held_rd_din", DIN, 8'h1F);
        repeat (2) @(negedge CLK);

        RD = 1'b1; WR = 1'b1; A = 16'h1000;
        rdy = 0; strb = 0;
        for (int i = 0; i < 5; i++) begin
            @(negedge CLK);
            if (READY) rdy++;
            if (EXT_RD || EXT_WR) strb++;
        end
        RD = 1'b0; WR = 1'b0;
        check("both_ready_cnt", rdy, 0);
        check("both_strobes", strb, 0);
        @(negedge CLK);

        WR = 1'b1; A = 16'h3000; DOUT = 8'h99;
        @(negedge CLK);
        check("rst_mid_ext_wr", EXT_WR, 1);
        SYNC_RES = 1'b1;
        @(negedge CLK);
        check("rst_mid_strobe", EXT_WR, 0);
        check("rst_mid_ready", READY, 0);
        SYNC_RES = 1'b0; WR = 1'b0;
        rdy = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            if (READY) rdy++;
        end
        check("rst_mid_no_ready", rdy, 0);
        run_access(mk(1, 0, 16'hFFFF, 8'h00, 0, 8'h00, 0, 2, 8'h00, 0));
`ifdef MEM_RESPONDER_HRAM_EN
        run_access(mk(1, 0, 16'hFF90, 8'h00, 0, 8'h00, 0, 2, 8'h5A, 0));
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter: WAIT_CYCLES, default 1, internal-access wait states (0..7).
REQ-002 Parameter: EXT_TIMEOUT, default 255, max cycles to wait for EXT_ACK (1..255).
REQ-003 CLK  in  1  single system clock; all state changes on rising edge.
REQ-004 SYNC_RES  in  1  reset, synchronous, active-high.
REQ-005 A  in  16  core external address bus.
REQ-006 DOUT  in  8  core write data.
REQ-007 RD / WR  in  1 each  core read / write request strobes.
REQ-008 DIN  out  8  read data returned to core.
REQ-009 READY  out  1  one-cycle completion pulse.
REQ-010 TIMEOUT  out  1  one-cycle pulse: external access abandoned.
REQ-011 EXT_A  out  16 / EXT_DO  out  8 / EXT_DI  in  8  external memory port address, write data, read data.
REQ-012 EXT_RD / EXT_WR  out  1 each  / EXT_ACK  in  1  external strobes and completion.

Function
REQ-013 FSM states SHALL be IDLE, WAIT, EXT, DONE, RELEASE.
REQ-014 IDLE: RD xor WR high SHALL latch A, DOUT and direction; later changes on A or DOUT SHALL be ignored until RELEASE exits.
REQ-015 RD and WR both high in IDLE SHALL be ignored; state stays IDLE.
REQ-016 Internal targets: HRAM FF80-FFFE, IE register FFFF; all other addresses are external.
REQ-017 Internal request: WAIT_CYCLES=0 -> DONE next cycle; else -> WAIT, counter loaded with WAIT_CYCLES, decremented each cycle, -> DONE when it reaches 1.
REQ-018 External request -> EXT; EXT_A/EXT_DO driven from latches, EXT_RD or EXT_WR held high for the whole EXT state.
REQ-019 EXT with EXT_ACK high SHALL capture EXT_DI into DIN (read) and go to DONE; strobes drop in DONE.
REQ-020 EXT without ACK for EXT_TIMEOUT cycles SHALL go to DONE with DIN=8'hFF on read; TIMEOUT pulses together with READY.
REQ-021 DONE: READY=1 for exactly one cycle; internal read data valid on DIN in the same cycle; internal write committed at DONE.
REQ-022 DIN SHALL hold its last value until the next read completes.
REQ-023 RELEASE: wait until RD=WR=0, then IDLE; a request held high across DONE is never re-serviced.
REQ-024 Total latency, request sample to READY: internal WAIT_CYCLES+1 cycles; external ACK-cycle+1.
REQ-025 HRAM index SHALL be A[6:0] for 0x00..0x7E; 0x7F is IE, never HRAM.

Reset
REQ-026 SYNC_RES SHALL force IDLE, READY=0, TIMEOUT=0, EXT_RD=EXT_WR=0, EXT_A=0, EXT_DO=0, DIN=8'hFF, IE=0, counters 0.
REQ-027 Reset mid-access SHALL abort it: strobes drop next edge, no READY, pending write not committed; HRAM contents preserved.

Configuration
REQ-028 Macro MEM_RESPONDER_HRAM_EN: defined -> HRAM instantiated internally per REQ-016; undefined -> FF80-FFFE forwarded externally, only FFFF internal.

Structure
REQ-029 Shared package dmg_bus_pkg: FSM state enum, HRAM_BASE=16'hFF80, IE_ADDR=16'hFFFF, OPEN_BUS=8'hFF.
REQ-030 One sub-module hram_127x8 (synchronous write, combinational read), instantiated only under MEM_RESPONDER_HRAM_EN.

Verification
REQ-031 WAIT_CYCLES=1: WR A=FF90 DOUT=5A, drop; RD FF90 -> READY 2 cycles after sample, DIN=5A.
REQ-032 External RD A=1234, EXT_ACK 3 cycles later with EXT_DI=C3 -> EXT_RD high 3 cycles, DIN=C3, READY next cycle.
REQ-033 External RD, EXT_ACK never, EXT_TIMEOUT=4 -> DONE after 4 cycles, DIN=FF, READY and TIMEOUT pulse together.
REQ-034 RD held high 10 cycles on FFFF after write of 1F -> exactly one READY, DIN=1F.
REQ-035 SYNC_RES asserted during EXT write -> EXT_WR low next edge, no READY, IE=0, earlier HRAM data still readable.
REQ-036 RD=WR=1 in IDLE for 5 cycles -> no strobes, no READY; without MEM_RESPONDER_HRAM_EN, RD FF80 -> EXT_RD asserted.
